// File: rtl/separable_output_first_allocator.sv
// Separable output-first allocator: per-resource round-robin picks an agent,
// then per-agent round-robin picks one of the resources that picked it.
module separable_output_first_allocator #(
  parameter int AGENTS_NUM    = 3,
  parameter int RESOURCES_NUM = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]    requests_i,
  output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]    grants_o
);

  localparam int unsigned A  = AGENTS_NUM;
  localparam int unsigned R  = RESOURCES_NUM;
  localparam int          AW = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;
  localparam int          RW = (RESOURCES_NUM > 1) ? $clog2(RESOURCES_NUM) : 1;

  logic [AW-1:0]            out_ptr [RESOURCES_NUM];
  logic [RW-1:0]            in_ptr  [AGENTS_NUM];
  logic [AGENTS_NUM-1:0]    col_sel [RESOURCES_NUM];
  logic [RESOURCES_NUM-1:0] row_gnt [AGENTS_NUM];

  // Stage 1: each resource picks one requesting agent, scanning from out_ptr
  for (genvar r = 0; r < RESOURCES_NUM; r++) begin : g_out_arb
    always_comb begin
      logic        found;
      int unsigned idx;
      col_sel[r] = '0;
      found      = 1'b0;
      idx        = 0;
      for (int unsigned k = 0; k < A; k++) begin
        idx = 32'(out_ptr[r]) + k;
        if (idx >= A) idx = idx - A;
        if (!found && requests_i[AW'(idx)][r]) begin
          col_sel[r][AW'(idx)] = 1'b1;
          found                = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_ptr[r] <= '0;
      end else begin
        for (int unsigned a = 0; a < A; a++) begin
          if (grants_o[AW'(a)][r])
            out_ptr[r] <= (a == A - 1) ? '0 : AW'(a + 1);
        end
      end
    end
  end

  // Stage 2: each agent accepts one of the resources that selected it
  for (genvar a = 0; a < AGENTS_NUM; a++) begin : g_in_arb
    always_comb begin
      logic        found;
      int unsigned idx;
      row_gnt[a] = '0;
      found      = 1'b0;
      idx        = 0;
      for (int unsigned k = 0; k < R; k++) begin
        idx = 32'(in_ptr[a]) + k;
        if (idx >= R) idx = idx - R;
        if (!found && col_sel[RW'(idx)][a]) begin
          row_gnt[a][RW'(idx)] = 1'b1;
          found                = 1'b1;
        end
      end
    end

    assign grants_o[a] = row_gnt[a];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        in_ptr[a] <= '0;
      end else begin
        for (int unsigned r = 0; r < R; r++) begin
          if (row_gnt[a][RW'(r)])
            in_ptr[a] <= (r == R - 1) ? '0 : RW'(r + 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_separable_output_first_allocator.sv
// Bench for separable_output_first_allocator: directed vectors at 3x3 plus
// random traffic at 3x3, 4x2 and 2x5 against a round-robin reference model.
module tb_separable_output_first_allocator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0][2:0] req33, gnt33;
  logic [3:0][1:0] req42, gnt42;
  logic [1:0][4:0] req25, gnt25;

  separable_output_first_allocator #(.AGENTS_NUM(3), .RESOURCES_NUM(3)) u_dut33 (
    .clk(clk), .rst(rst), .requests_i(req33), .grants_o(gnt33));
  separable_output_first_allocator #(.AGENTS_NUM(4), .RESOURCES_NUM(2)) u_dut42 (
    .clk(clk), .rst(rst), .requests_i(req42), .grants_o(gnt42));
  separable_output_first_allocator #(.AGENTS_NUM(2), .RESOURCES_NUM(5)) u_dut25 (
    .clk(clk), .rst(rst), .requests_i(req25), .grants_o(gnt25));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: round-robin pointers per configuration
  int op [3][8];
  int ip [3][8];
  int NA [3] = '{3, 4, 2};
  int NR [3] = '{3, 2, 5};

  typedef struct {
    bit         do_rst;
    logic [8:0] req;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) begin
        op[c][i] = 0;
        ip[c][i] = 0;
      end
  endfunction

  function automatic logic [63:0] model_grant(input int c, input logic [63:0] req);
    bit          sel [8][8];
    logic [63:0] g;
    int          na, nr, a, r;
    na = NA[c];
    nr = NR[c];
    g  = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) sel[i][j] = 1'b0;
    for (int rr = 0; rr < nr; rr++)
      for (int k = 0; k < na; k++) begin
        a = (op[c][rr] + k) % na;
        if (req[a*nr + rr]) begin
          sel[a][rr] = 1'b1;
          break;
        end
      end
    for (int aa = 0; aa < na; aa++)
      for (int k = 0; k < nr; k++) begin
        r = (ip[c][aa] + k) % nr;
        if (sel[aa][r]) begin
          g[aa*nr + r] = 1'b1;
          break;
        end
      end
    return g;
  endfunction

  function automatic void model_commit(input int c, input logic [63:0] g);
    for (int a = 0; a < NA[c]; a++)
      for (int r = 0; r < NR[c]; r++)
        if (g[a*NR[c] + r]) begin
          op[c][r] = (a + 1) % NA[c];
          ip[c][a] = (r + 1) % NR[c];
        end
  endfunction

  // One grant per row and column, and only where requested
  function automatic logic [63:0] legal(input int c, input logic [63:0] req, input logic [63:0] g);
    int cnt;
    if ((g & ~req) != 0) return 64'd0;
    for (int a = 0; a < NA[c]; a++) begin
      cnt = 0;
      for (int r = 0; r < NR[c]; r++) cnt += int'(g[a*NR[c] + r]);
      if (cnt > 1) return 64'd0;
    end
    for (int r = 0; r < NR[c]; r++) begin
      cnt = 0;
      for (int a = 0; a < NA[c]; a++) cnt += int'(g[a*NR[c] + r]);
      if (cnt > 1) return 64'd0;
    end
    return 64'd1;
  endfunction

  function automatic logic [63:0] get_gnt(input int c);
    case (c)
      0:       return 64'(gnt33);
      1:       return 64'(gnt42);
      default: return 64'(gnt25);
    endcase
  endfunction

  task automatic set_req(input int c, input logic [63:0] v);
    case (c)
      0:       req33 = v[8:0];
      1:       req42 = v[7:0];
      default: req25 = v[9:0];
    endcase
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rq   [3];
    logic [63:0] expg [3];
    logic [63:0] mask;

    req33 = '0;
    req42 = '0;
    req25 = '0;

    // Directed 3x3 vectors: bit index = agent*3 + resource
    vecs.push_back('{1'b1, 9'h1FF, 9'h001});
    vecs.push_back('{1'b0, 9'h1FF, 9'h00A});
    vecs.push_back('{1'b0, 9'h1FF, 9'h054});
    vecs.push_back('{1'b1, 9'h000, 9'h000});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 9'h000, 9'h000});
    vecs.push_back('{1'b0, 9'h020, 9'h020});
    vecs.push_back('{1'b1, 9'h080, 9'h080});
    vecs.push_back('{1'b0, 9'h080, 9'h080});
    vecs.push_back('{1'b0, 9'h080, 9'h080});
    vecs.push_back('{1'b1, 9'h009, 9'h001});
    vecs.push_back('{1'b0, 9'h009, 9'h008});
    vecs.push_back('{1'b0, 9'h009, 9'h001});
    vecs.push_back('{1'b0, 9'h009, 9'h008});

    #12;
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].do_rst) apply_reset();
      req33 = vecs[i].req;
      #1;
      check($sformatf("vec%0d", i), 64'(gnt33), 64'(vecs[i].exp));
    end

    // Reset pulsed between edges mid-traffic
    @(negedge clk);
    apply_reset();
    req33 = 9'h1FF;
    #1 check("seq_c1", 64'(gnt33), 64'h001);
    @(negedge clk); #1 check("seq_c2", 64'(gnt33), 64'h00A);
    @(negedge clk); #1 check("seq_c3", 64'(gnt33), 64'h054);
    #1 rst = 1'b0;
    #1 check("rst_pulse_low", 64'(gnt33), 64'h001);
    #1 rst = 1'b1;
    #1 check("rst_pulse_after", 64'(gnt33), 64'h001);
    @(negedge clk); #1 check("rst_first_edge", 64'(gnt33), 64'h00A);

    // Reset held across a clock edge keeps pointers at 0
    rst   = 1'b0;
    req33 = 9'h080;
    #1 check("rst_held_grant", 64'(gnt33), 64'h080);
    @(negedge clk);
    req33 = 9'h1FF;
    #1 check("rst_held_ptrs", 64'(gnt33), 64'h001);
    rst = 1'b1;

    // Random traffic against the reference model
    @(negedge clk);
    set_req(0, '0);
    set_req(1, '0);
    set_req(2, '0);
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
        mask  = (64'd1 << (NA[c] * NR[c])) - 64'd1;
        rq[c] = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) rq[c] &= {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) rq[c] = '0;
        rq[c] &= mask;
        set_req(c, rq[c]);
      end
      #1;
      for (int c = 0; c < 3; c++) begin
        expg[c] = model_grant(c, rq[c]);
        check($sformatf("rand_%0dx%0d_grant", NA[c], NR[c]), get_gnt(c), expg[c]);
        check($sformatf("rand_%0dx%0d_legal", NA[c], NR[c]), legal(c, rq[c], get_gnt(c)), 64'd1);
      end
      @(posedge clk);
      for (int c = 0; c < 3; c++) model_commit(c, expg[c]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/separable_output_first_allocator.md
SEPARABLE_OUTPUT_FIRST_ALLOCATOR -- requirements
Module: separable_output_first_allocator

Interface
REQ-001 SHALL have parameter AGENTS_NUM, default 3, number of requesting agents (rows).
REQ-002 SHALL have parameter RESOURCES_NUM, default 3, number of allocatable resources (columns).
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port requests_i  input  [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]  requests_i[a][r]=1: agent a requests resource r.
REQ-007 SHALL have port grants_o  output  [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]  grants_o[a][r]=1: resource r granted to agent a this cycle.

Function
REQ-008 SHALL hold one output-side pointer out_ptr[r] per resource, width max(1,$clog2(AGENTS_NUM)), range 0..AGENTS_NUM-1.
REQ-009 SHALL hold one input-side pointer in_ptr[a] per agent, width max(1,$clog2(RESOURCES_NUM)), range 0..RESOURCES_NUM-1.
REQ-010 Stage 1 (output arbitration), per resource r: SHALL select the first agent a, scanning cyclically from out_ptr[r] upward (out_ptr[r], +1, ... mod AGENTS_NUM), with requests_i[a][r]=1; sel[a][r]=1 for that agent only; no requester -> column r of sel all 0.
REQ-011 Stage 2 (input arbitration), per agent a: SHALL select the first resource r, scanning cyclically from in_ptr[a] (mod RESOURCES_NUM), with sel[a][r]=1; grants_o[a][r]=1 for that resource only; none -> row a all 0.
REQ-012 grants_o SHALL be combinational from requests_i and current pointers (zero-cycle latency); no output register.
REQ-013 grants_o SHALL have at most one 1 per row and at most one 1 per column, and grants_o[a][r]=1 only if requests_i[a][r]=1.
REQ-014 On rising clk with grants_o[a][r]=1: out_ptr[r] <= (a+1) mod AGENTS_NUM and in_ptr[a] <= (r+1) mod RESOURCES_NUM.
REQ-015 Pointers of arbiters without a final grant (including stage-1 winners rejected in stage 2) SHALL hold their value.
REQ-016 Pointer wrap: value N-1 advances to 0, including for non-power-of-two N; pointer SHALL never hold a value >= N.
REQ-017 requests_i all zero SHALL give grants_o all zero and leave all pointers unchanged.
REQ-018 Requests may change every cycle; no request needs to be held, and no state beyond pointers exists.
REQ-019 Arbiter logic SHALL be generated per row/column for arbitrary AGENTS_NUM, RESOURCES_NUM >= 1, including non-square configurations.

Reset
REQ-020 rst=0 SHALL asynchronously force every out_ptr and in_ptr to 0, independent of clk.
REQ-021 While rst=0, grants_o SHALL still be the combinational result with all pointers 0 (lowest index wins at both stages).
REQ-022 Reset asserted mid-operation SHALL discard all priority history; first edge after rst returns to 1 updates per REQ-014 from pointer value 0.

Verification (3x3 default)
REQ-023 After reset, requests all ones, 3 cycles -> cycle1 grants only [0][0]; cycle2 [0][1],[1][0]; cycle3 [0][2],[1][1],[2][0].
REQ-024 requests all zero for 5 cycles, then single request [1][2] -> grants zero for 5 cycles, then grant [1][2]; pointers unchanged (all 0) before the request.
REQ-025 Only request [2][1] held 3 cycles -> grant [2][1] every cycle; out_ptr[1]=0, in_ptr[2]=2 after first edge.
REQ-026 Agents 0 and 1 both request only resource 0 for 4 cycles -> grant alternates [0][0],[1][0],[0][0],[1][0].
REQ-027 rst pulsed low between clock edges during REQ-023 traffic -> pointers 0 immediately, grants_o returns to [0][0] same cycle.
REQ-028 10000 cycles random requests, also at 4x2 and 2x5 -> grants_o matches a cycle-accurate model of REQ-010..REQ-016 every cycle; REQ-013 holds every cycle.
